// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalizer FSM encoding and the default single-precision format constants.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  localparam int FP_EXP_WIDTH  = 8;
  localparam int FP_MANT_WIDTH = 23;

  localparam logic [FP_EXP_WIDTH-1:0] EXP_MAX  = '1;
  localparam logic [FP_EXP_WIDTH-1:0] EXP_BIAS = FP_EXP_WIDTH'(127);

  // Bit positions inside the raw significand sum {carry, hidden, fraction}.
  localparam int CARRY_BIT  = FP_MANT_WIDTH + 1;
  localparam int HIDDEN_BIT = FP_MANT_WIDTH;

endpackage

// File: rtl/fp_post_normalizer_if.sv
// Handshake bundle between the adder core, the post-normalizer and the rounding stage.
interface fp_post_normalizer_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
);

  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_WIDTH+1:0] in_mant;
  logic [EXP_WIDTH-1:0]  in_exp;
  logic                  in_sign;

  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_WIDTH-1:0] out_mant;
  logic [EXP_WIDTH-1:0]  out_exp;
  logic                  out_sign;
  logic                  out_sticky;
  logic                  out_overflow;
  logic                  out_zero;

  modport master (
    output in_valid, in_mant, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign,
           out_sticky, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign,
           out_sticky, out_overflow, out_zero
  );

endinterface

// File: rtl/fp_lzc.sv
// Parameterized leading-zero counter; used by fp_post_normalizer only when FPU_NORM_FAST_EN is defined.
module fp_lzc #(
  parameter int WIDTH = 24,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Scanning upward lets the most significant set bit have the final say.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_post_normalizer.sv
// FPU adder post-normalization: shifts the raw sum to normal/denormal form and fixes the exponent.
// Define FPU_NORM_FAST_EN for a single-cycle LZC-based shift instead of one bit per cycle.
module fp_post_normalizer
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = FP_EXP_WIDTH,
  parameter int MANT_WIDTH = FP_MANT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  fp_post_normalizer_if.slave bus
);

  localparam int SIG_W      = MANT_WIDTH + 2;
  localparam int CARRY_IDX  = MANT_WIDTH + 1;
  localparam int HIDDEN_IDX = MANT_WIDTH;
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_ONE  = EXP_WIDTH'(1);

  norm_state_t          state_q, state_d;
  logic [SIG_W-1:0]     mant_q, mant_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic                 sticky_q, sticky_d;
  logic                 overflow_q, overflow_d;
  logic                 zero_q, zero_d;
  logic [EXP_WIDTH-1:0] exp_inc;

  assign exp_inc = exp_q + 1'b1;

`ifdef FPU_NORM_FAST_EN
  localparam int LZ_W = $clog2(MANT_WIDTH + 2);

  logic [LZ_W-1:0]           lz;
  logic [EXP_WIDTH+LZ_W-1:0] lz_ext, room_ext, shamt;

  fp_lzc #(
    .WIDTH (MANT_WIDTH + 1),
    .CW    (LZ_W)
  ) u_lzc (
    .value (mant_q[MANT_WIDTH:0]),
    .count (lz)
  );

  // The exponent can only give up exp-1 positions before the value becomes denormal.
  assign lz_ext   = {{EXP_WIDTH{1'b0}}, lz};
  assign room_ext = {{LZ_W{1'b0}}, exp_q - 1'b1};
  assign shamt    = (lz_ext > room_ext) ? room_ext : lz_ext;
`endif

  always_comb begin
    state_d    = state_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sticky_d   = sticky_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mant_d     = bus.in_mant;
          exp_d      = bus.in_exp;
          sign_d     = bus.in_sign;
          sticky_d   = 1'b0;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
          state_d    = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[CARRY_IDX]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_inc;
          if (exp_inc == EXP_ONES) begin
            mant_d     = '0;
            overflow_d = 1'b1;
          end
          state_d = DONE;
        end else if (mant_q[HIDDEN_IDX] || (exp_q == '0)) begin
          state_d = DONE;
`ifdef FPU_NORM_FAST_EN
        end else begin
          mant_d  = mant_q << shamt;
          exp_d   = (lz_ext > room_ext) ? '0 : (exp_q - lz_ext[EXP_WIDTH-1:0]);
          state_d = DONE;
        end
`else
        end else if (exp_q == EXP_ONE) begin
          exp_d   = '0;
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 1'b1;
        end
`endif
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mant_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      sticky_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_mant     = mant_q[MANT_WIDTH-1:0];
  assign bus.out_exp      = exp_q;
  assign bus.out_sign     = sign_q;
  assign bus.out_sticky   = sticky_q;
  assign bus.out_overflow = overflow_q;
  assign bus.out_zero     = zero_q;

endmodule

// File: tb/tb_fp_post_normalizer.sv
// Directed bench for fp_post_normalizer; expected latencies follow FPU_NORM_FAST_EN when defined.
module tb_fp_post_normalizer;

  localparam int EW = 8;
  localparam int MW = 23;

`ifdef FPU_NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  fp_post_normalizer_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) bus ();

  fp_post_normalizer #(
    .EXP_WIDTH  (EW),
    .MANT_WIDTH (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Sends one operand, waits for the result, checks it, optionally holds it, then drains it.
  task automatic applyStimulus(
    input string       name,
    input logic [24:0] mant,
    input logic [7:0]  exp,
    input logic        sign,
    input int          k_iter,
    input logic [22:0] m_want,
    input logic [7:0]  e_want,
    input logic        st_want,
    input logic        ov_want,
    input logic        z_want,
    input int          hold
  );
    int n;
    int k_want;
    k_want = FAST ? 1 : k_iter;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_mant  = mant;
    bus.in_exp   = exp;
    bus.in_sign  = sign;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, ".latency"},  32'(n),                k_want + 1);
    checkOutput({name, ".mant"},     32'(bus.out_mant),     32'(m_want));
    checkOutput({name, ".exp"},      32'(bus.out_exp),      32'(e_want));
    checkOutput({name, ".sticky"},   32'(bus.out_sticky),   32'(st_want));
    checkOutput({name, ".overflow"}, 32'(bus.out_overflow), 32'(ov_want));
    checkOutput({name, ".zero"},     32'(bus.out_zero),     32'(z_want));
    checkOutput({name, ".sign"},     32'(bus.out_sign),     32'(sign));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mant  = 25'h1FFFFFF;
      bus.in_exp   = 8'h11;
      @(posedge clk); #1;
      checkOutput({name, ".hold_mant"}, 32'(bus.out_mant), 32'(m_want));
      checkOutput({name, ".hold_ctl"},
                  32'({bus.in_ready, bus.out_valid, bus.out_exp}),
                  32'({1'b0, 1'b1, e_want}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({name, ".released"}, 32'({bus.in_ready, bus.out_valid}), 32'h2);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ctl", 32'({bus.in_ready, bus.out_valid}), 32'h2);
    checkOutput("reset.data",
                32'({bus.out_mant, bus.out_sticky, bus.out_overflow, bus.out_zero, bus.out_sign}),
                32'h0);
    checkOutput("reset.exp", 32'(bus.out_exp), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    //            name       in_mant      in_exp  sgn  k   out_mant    out_exp st ov z  hold
    applyStimulus("carry",    25'h1800000, 8'h80, 1'b0, 1, 23'h400000, 8'h81, 0, 0, 0, 0);
    applyStimulus("carry_st", 25'h1800001, 8'h80, 1'b1, 1, 23'h400000, 8'h81, 1, 0, 0, 0);
    applyStimulus("lshift23", 25'h0000001, 8'h80, 1'b0, 24, 23'h000000, 8'h69, 0, 0, 0, 0);
    applyStimulus("ovf",      25'h1000000, 8'hFE, 1'b0, 1, 23'h000000, 8'hFF, 0, 1, 0, 0);
    applyStimulus("ovf_st",   25'h1000001, 8'hFE, 1'b1, 1, 23'h000000, 8'hFF, 1, 1, 0, 0);
    applyStimulus("zero",     25'h0000000, 8'h55, 1'b1, 1, 23'h000000, 8'h00, 0, 0, 1, 0);
    applyStimulus("denorm",   25'h0000100, 8'h03, 1'b0, 3, 23'h000400, 8'h00, 0, 0, 0, 0);
    applyStimulus("lshift2",  25'h0200000, 8'h10, 1'b1, 3, 23'h000000, 8'h0E, 0, 0, 0, 0);
    applyStimulus("exp0",     25'h0000100, 8'h00, 1'b0, 1, 23'h000100, 8'h00, 0, 0, 0, 0);
    applyStimulus("exp1",     25'h0400000, 8'h01, 1'b0, 1, 23'h400000, 8'h00, 0, 0, 0, 0);
    applyStimulus("hold",     25'h0C00000, 8'h20, 1'b1, 1, 23'h400000, 8'h20, 0, 0, 0, 5);

    // Abort a long iterative normalization with reset partway through.
    bus.in_valid = 1'b1;
    bus.in_mant  = 25'h0000001;
    bus.in_exp   = 8'h80;
    bus.in_sign  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (FAST ? 0 : 3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst.ctl", 32'({bus.in_ready, bus.out_valid}), 32'h2);
    checkOutput("midrst.exp", 32'(bus.out_exp), 32'h0);
    checkOutput("midrst.sign", 32'(bus.out_sign), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("post_rst", 25'h1800000, 8'h80, 1'b0, 1, 23'h400000, 8'h81, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
